// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running pixel/line counters with registered sync,
// visible-region and coordinate outputs, plus combinational end-of-line/frame strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_end,
  output logic          frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_LAST   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_VIS_LAST   = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] H_SYNC_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_SYNC_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_ON        = (HS_POL != 0);
  localparam logic          VS_ON        = (VS_POL != 0);

  logic [CW-1:0] h_count_q, h_count_d;
  logic [CW-1:0] v_count_q, v_count_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;

  logic h_last, v_last, h_in_sync, v_in_sync, h_vis, v_vis;

  always_comb begin
    h_last    = (h_count_q == H_LAST);
    v_last    = (v_count_q == V_LAST);
    h_in_sync = (h_count_q >= H_SYNC_FIRST) && (h_count_q <= H_SYNC_LAST);
    v_in_sync = (v_count_q >= V_SYNC_FIRST) && (v_count_q <= V_SYNC_LAST);
    h_vis     = (h_count_q <= H_VIS_LAST);
    v_vis     = (v_count_q <= V_VIS_LAST);

    line_end  = rst_n & en & h_last;
    frame_end = line_end & v_last;

    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (en) begin
      if (h_last) begin
        h_count_d = '0;
        v_count_d = v_last ? '0 : v_count_q + CW'(1);
      end else begin
        h_count_d = h_count_q + CW'(1);
      end
    end

    // Output registers sample the pre-edge counters every cycle, regardless of en.
    hsync_d  = h_in_sync ? HS_ON : ~HS_ON;
    vsync_d  = v_in_sync ? VS_ON : ~VS_ON;
    active_d = h_vis & v_vis;
    x_d      = active_d ? h_count_q : '0;
    y_d      = active_d ? v_count_q : '0;

    if (!rst_n) begin
      h_count_d = '0;
      v_count_d = '0;
      hsync_d   = ~HS_ON;
      vsync_d   = ~VS_ON;
      active_d  = 1'b0;
      x_d       = '0;
      y_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    h_count_q <= h_count_d;
    v_count_q <= v_count_d;
    hsync_q   <= hsync_d;
    vsync_q   <= vsync_d;
    active_q  <= active_d;
    x_q       <= x_d;
    y_q       <= y_d;
  end

  assign h_count = h_count_q;
  assign v_count = v_count_q;
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign active  = active_q;
  assign x       = x_q;
  assign y       = y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a tiny 8x6 raster for vectors and corners, the 800x525 default for line timing.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a;
  logic [9:0] h_a, v_a, x_a, y_a;
  logic       hs_a, vs_a, act_a, le_a, fe_a;

  logic       rst_b, en_b;
  logic [3:0] h_b, v_b, x_b, y_b;
  logic       hs_b, vs_b, act_b, le_b, fe_b;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_a), .en(en_a),
    .h_count(h_a), .v_count(v_a), .hsync(hs_a), .vsync(vs_a), .active(act_a),
    .x(x_a), .y(y_a), .line_end(le_a), .frame_end(fe_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CW(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .en(en_b),
    .h_count(h_b), .v_count(v_b), .hsync(hs_b), .vsync(vs_b), .active(act_b),
    .x(x_b), .y(y_b), .line_end(le_b), .frame_end(fe_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic rst_n;
    logic en;
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic act;
    int   x;
    int   y;
    logic le;
    logic fe;
  } vec_t;

  vec_t tbl[16];

  initial begin
    rst_a = 1'b0; en_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b1;

    // rst, en | post-edge h v hs vs act x y | pre-edge le fe
    tbl[0]  = '{1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 2, 0, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2, 0, 1'b0, 1'b0, 1'b1, 2, 0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 3, 0, 1'b0, 1'b0, 1'b1, 2, 0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 4, 0, 1'b0, 1'b0, 1'b1, 3, 0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 5, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 6, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 7, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 7, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1, 1, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 2, 1, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst_b = tbl[i].rst_n;
      en_b  = tbl[i].en;
      #1;
      chk($sformatf("v%0d line_end", i), le_b, tbl[i].le);
      chk($sformatf("v%0d frame_end", i), fe_b, tbl[i].fe);
      @(posedge clk); #1;
      chk($sformatf("v%0d h_count", i), h_b, tbl[i].h);
      chk($sformatf("v%0d v_count", i), v_b, tbl[i].v);
      chk($sformatf("v%0d hsync", i), hs_b, tbl[i].hs);
      chk($sformatf("v%0d vsync", i), vs_b, tbl[i].vs);
      chk($sformatf("v%0d active", i), act_b, tbl[i].act);
      chk($sformatf("v%0d x", i), x_b, tbl[i].x);
      chk($sformatf("v%0d y", i), y_b, tbl[i].y);
    end

    // Full small frame from reset: cycle-by-cycle latency check plus per-frame totals.
    begin
      int err = 0, n_act = 0, n_hs = 0, n_vs = 0, n_le = 0, n_fe = 0;
      int ph, pv;
      @(negedge clk); rst_b = 1'b0; en_b = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 48; c++) begin
        @(negedge clk); rst_b = 1'b1; en_b = 1'b1; #1;
        ph = int'(h_b); pv = int'(v_b);
        n_le += int'(le_b); n_fe += int'(fe_b);
        if (le_b !== (ph == 7)) err++;
        if (fe_b !== (ph == 7 && pv == 5)) err++;
        @(posedge clk); #1;
        if (hs_b !== (ph == 5 || ph == 6)) err++;
        if (vs_b !== (pv == 4)) err++;
        if (act_b !== (ph < 4 && pv < 3)) err++;
        if (int'(x_b) != ((ph < 4 && pv < 3) ? ph : 0)) err++;
        if (int'(y_b) != ((ph < 4 && pv < 3) ? pv : 0)) err++;
        if (int'(h_b) != (ph + 1) % 8) err++;
        if (int'(v_b) != ((ph == 7) ? (pv + 1) % 6 : pv)) err++;
        n_act += int'(act_b); n_hs += int'(hs_b); n_vs += int'(vs_b);
      end
      chk("small frame per-cycle errors", err, 0);
      chk("small frame active count", n_act, 12);
      chk("small frame hsync count", n_hs, 12);
      chk("small frame vsync count", n_vs, 8);
      chk("small frame line_end count", n_le, 6);
      chk("small frame frame_end count", n_fe, 1);
    end

    // Wrap corner: last pixel of last line.
    begin
      logic found = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk); en_b = 1'b1; #1;
        if (h_b == 4'd7 && v_b == 4'd5) begin found = 1'b1; break; end
      end
      chk("wrap corner reached", found, 1'b1);
      chk("wrap line_end", le_b, 1'b1);
      chk("wrap frame_end", fe_b, 1'b1);
      @(posedge clk); #1;
      chk("wrap h_count", h_b, 0);
      chk("wrap v_count", v_b, 0);
    end

    // Reset inside vsync on the last pixel of a line: reset wins over en.
    begin
      logic found = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk); en_b = 1'b1; #1;
        if (h_b == 4'd7 && v_b == 4'd4) begin found = 1'b1; break; end
      end
      chk("midsync point reached", found, 1'b1);
      rst_b = 1'b0; #1;
      chk("midsync reset line_end", le_b, 1'b0);
      chk("midsync reset frame_end", fe_b, 1'b0);
      @(posedge clk); #1;
      chk("midsync reset h_count", h_b, 0);
      chk("midsync reset v_count", v_b, 0);
      chk("midsync reset vsync", vs_b, 1'b0);
      chk("midsync reset hsync", hs_b, 1'b0);
      chk("midsync reset active", act_b, 1'b0);
      @(negedge clk); rst_b = 1'b1; en_b = 1'b1;
      @(posedge clk); #1;
      chk("restart h_count", h_b, 1);
      chk("restart v_count", v_b, 0);
      chk("restart active", act_b, 1'b1);
      chk("restart x", x_b, 0);
      chk("restart y", y_b, 0);
      chk("restart vsync", vs_b, 1'b0);
    end

    // Default 800x525 timing over two lines: hsync active-low for 656..751.
    begin
      int err = 0, n_low = 0, n_le = 0, n_fe = 0, first_low = -1;
      int ph, pv;
      @(negedge clk); rst_a = 1'b0; en_a = 1'b1;
      @(posedge clk); #1;
      chk("default reset h_count", h_a, 0);
      chk("default reset hsync", hs_a, 1'b1);
      chk("default reset vsync", vs_a, 1'b1);
      for (int c = 0; c < 1600; c++) begin
        @(negedge clk); rst_a = 1'b1; en_a = 1'b1; #1;
        ph = int'(h_a); pv = int'(v_a);
        n_le += int'(le_a); n_fe += int'(fe_a);
        @(posedge clk); #1;
        if (hs_a !== !(ph >= 656 && ph <= 751)) err++;
        if (vs_a !== 1'b1) err++;
        if (act_a !== (ph < 640 && pv < 480)) err++;
        if (int'(x_a) != ((ph < 640 && pv < 480) ? ph : 0)) err++;
        if (hs_a == 1'b0) begin
          n_low++;
          if (first_low < 0) first_low = ph;
        end
      end
      chk("default per-cycle errors", err, 0);
      chk("default hsync low clocks", n_low, 192);
      chk("default hsync first low h_count", first_low, 656);
      chk("default line_end count", n_le, 2);
      chk("default frame_end count", n_fe, 0);
      chk("default v_count after 2 lines", v_a, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front-porch pixels.
REQ-003 Parameter H_SYNC, default 96: horizontal sync-pulse pixels.
REQ-004 Parameter H_BP, default 48: horizontal back-porch pixels.
REQ-005 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 Parameter V_FP, default 10: vertical front-porch lines.
REQ-007 Parameter V_SYNC, default 2: vertical sync-pulse lines.
REQ-008 Parameter V_BP, default 33: vertical back-porch lines.
REQ-009 Parameter HS_POL, default 0: hsync asserted level (0 = active-low).
REQ-010 Parameter VS_POL, default 0: vsync asserted level (0 = active-low).
REQ-011 Parameter CW, default 10: counter width; H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP SHALL each be <= 2^CW.
REQ-012 clk  input  1  single clock; all state updates on rising edge.
REQ-013 rst_n  input  1  reset, synchronous, active-low.
REQ-014 en  input  1  pixel-advance enable; counters step only when high.
REQ-015 h_count  output  CW  horizontal counter, 0..H_TOTAL-1.
REQ-016 v_count  output  CW  vertical counter, 0..V_TOTAL-1.
REQ-017 hsync  output  1  registered horizontal sync, polarity HS_POL.
REQ-018 vsync  output  1  registered vertical sync, polarity VS_POL.
REQ-019 active  output  1  registered visible-region flag.
REQ-020 x  output  CW  registered pixel column; 0 outside visible region.
REQ-021 y  output  CW  registered pixel row; 0 outside visible region.
REQ-022 line_end  output  1  strobe: last pixel of a line being consumed.
REQ-023 frame_end  output  1  strobe: last pixel of a frame being consumed.

Function
REQ-024 With en=1 at a clk edge, h_count SHALL increment by 1, wrapping from H_TOTAL-1 to 0; with en=0, h_count and v_count SHALL hold.
REQ-025 v_count SHALL increment only at an edge where en=1 and h_count=H_TOTAL-1, wrapping from V_TOTAL-1 to 0 at the same edge h_count wraps.
REQ-026 Line order SHALL be: visible [0,H_ACTIVE-1], front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], back porch; vertical identical with V_* values.
REQ-027 hsync, vsync, active, x, y SHALL be registered every clk edge (independent of en) from the counter values present before that edge: exactly one clk of latency relative to h_count/v_count.
REQ-028 hsync SHALL equal HS_POL when the source h_count is in the sync range, else ~HS_POL; vsync likewise for v_count with VS_POL.
REQ-029 active SHALL be 1 iff source h_count<H_ACTIVE and v_count<V_ACTIVE; x/y SHALL then equal the source h_count/v_count, else 0.
REQ-030 line_end SHALL be combinational: 1 iff en=1 and h_count=H_TOTAL-1.
REQ-031 frame_end SHALL be combinational: 1 iff line_end=1 and v_count=V_TOTAL-1.
REQ-032 Counter arithmetic SHALL be CW-bit unsigned; no state other than the two counters and the output registers.
REQ-033 Simultaneous en=1 and rst_n=0: reset SHALL win.

Reset
REQ-034 At a clk edge with rst_n=0: h_count=0, v_count=0, hsync=~HS_POL, vsync=~VS_POL, active=0, x=0, y=0, regardless of en or current state (including mid-line/mid-sync).
REQ-035 line_end and frame_end SHALL be 0 while rst_n=0.
REQ-036 First edge after rst_n returns high with en=1: h_count=1, active=1, x=0, y=0.

Verification
REQ-037 Defaults, en=1 constantly, 2 frames -> hsync low for exactly 96 clks each 800-clk line, starting h_count 656; vsync low exactly 2 lines (1600 clks) per 420000-clk frame; frame_end once per 420000 clks.
REQ-038 H=4/1/2/1, V=3/1/1/1, CW=4, HS_POL=VS_POL=1 -> H_TOTAL=8, V_TOTAL=6; hsync high one clk after h_count=5 and 6; active count 12 per 48-clk frame.
REQ-039 en toggling 1,0,1,0 -> counters advance every other clk; registered outputs stable across en=0 clks; line_end only with en=1.
REQ-040 rst_n=0 asserted for one clk at h_count=700, v_count=491 (inside vsync) -> next edge counters 0, vsync/hsync inactive, active=0; sequence restarts cleanly.
REQ-041 Wrap corner: h_count=799, v_count=524, en=1 -> line_end=frame_end=1 that cycle; next edge both counters 0.
REQ-042 en=1 with rst_n=0 for 3 clks -> counters remain 0, strobes 0 throughout.
